collatz_dispatch: RTL and testbench
===================================

Name: collatz_dispatch

Overview:
- Scheduler that fills the results RAM with Collatz iteration counts for RAM_WORDS consecutive start values, base .. base+RAM_WORDS-1.
- Farms the work out to NCORES single-value Collatz iteration cores using per-core go/done handshakes.
- Arbitrates the cores' results onto the single RAM write port.
- Sits between the top-level go/done control and the results RAM, in place of a single-core sweep.

Parameters:
- NCORES, 4, number of Collatz iteration cores served (1..8).
- RAM_WORDS, 256, number of start values per sweep, one RAM word each.
- RAM_ADDR_BITS, 8, RAM address width; must satisfy 2^RAM_ADDR_BITS >= RAM_WORDS.
- N_BITS, 32, start value width.
- C_BITS, 16, iteration count width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- go  in  1  start a sweep; sampled only in IDLE.
- base  in  N_BITS  first start value; captured on accepted go.
- busy  out  1  high from the cycle after an accepted go until done.
- done  out  1  one-cycle pulse when all RAM_WORDS results are written.
- core_go  out  NCORES  one-cycle start pulse per core.
- core_n  out  NCORES*N_BITS  start value per core; slice k drives core k.
- core_done  in  NCORES  one-cycle pulse from core k; core_count slice k is valid in that cycle.
- core_count  in  NCORES*C_BITS  iteration count per core.
- we  out  1  RAM write enable.
- waddr  out  RAM_ADDR_BITS  RAM write address (index of the start value).
- wdata  out  C_BITS  RAM write data.

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, we=0, waddr=0, wdata=0.
  - core_go=0, core_n=0, all per-core state cleared, issue counter=0.
  - Cores share the same reset.
- States: IDLE, RUN, FIN.
- IDLE:
  - go=1 -> capture base, issue index=0, go to RUN; busy=1 from the next cycle.
- go outside IDLE is ignored.
- Per-core status: FREE, RUNNING, or PENDING (result held in a one-entry register with its tag index).
- Dispatch in RUN, at most one per cycle:
  - Condition: issue index < RAM_WORDS and some core is FREE.
  - Target: the lowest-numbered FREE core k.
  - Effects: core_go[k]=1 for one cycle; core_n[k]=base+index (mod 2^N_BITS); tag[k]=index; index++; k becomes RUNNING.
  - core_n[k] is held stable until the next dispatch to k.
- Capture: core_done[k] while RUNNING -> latch core_count[k]; k becomes PENDING next cycle.
- core_done for a core that is not RUNNING is ignored.
- Writeback arbitration:
  - Each cycle, the lowest-numbered PENDING core j is written: we=1, waddr=tag[j], wdata=count[j], registered (appears 1 cycle after selection).
  - j becomes FREE and is dispatchable the cycle after its write.
  - Fixed priority; no starvation, because the issue count is finite.
- Latency:
  - go accept to first core_go: 1 cycle.
  - core_done to we for the same result, uncontended: 2 cycles.
- Simultaneous events:
  - Capture, writeback and dispatch may occur in the same cycle on different cores.
  - Several core_done in the same cycle are all captured; writes are serialised by priority.
- Write order follows completion and priority, not index; every address 0..RAM_WORDS-1 is written exactly once per sweep.
- Completion:
  - When index==RAM_WORDS and all cores are FREE with no write in flight -> FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- A new go is accepted the cycle after done.
- reset mid-sweep: abandon immediately; no further we; outputs return to reset values next cycle.
- RAM_WORDS < NCORES: only RAM_WORDS dispatches occur; the remaining cores stay idle.

Test Plan:
- Reset, then go with base=1, NCORES=4, model cores with fixed 3-cycle latency -> core_go to cores 0..3 on cycles 1..4; 256 writes, waddr k -> wdata count(1+k) (count(1)=0, count(3)=7, count(27)=111); done once, after the last write.
- Cores 1 and 2 pulse core_done in the same cycle -> core 1 written first, core 2 next cycle; neither result lost; core 1 redispatched before core 2.
- Model core latency = count(n), base=7 -> out-of-order completion; RAM contents match the reference model for n=7..262; every address written once.
- go pulsed during RUN and again in the FIN cycle -> ignored; sweep unaffected; go the cycle after done starts a new sweep with the new base.
- reset asserted 50 cycles into a sweep -> we=0 and busy=0 next cycle; a subsequent go with base=100 completes a clean sweep.
- base=32'hFFFF_FFF0 -> core_n wraps to 0 after 16 issues; waddr 16 receives the count for n=0 from the model.

Source files
------------

// File: rtl/collatz_dispatch.sv
// Sweep scheduler: issues base..base+RAM_WORDS-1 to NCORES Collatz cores and
// serialises their results onto the single results-RAM write port.
module collatz_dispatch #(
   parameter int NCORES        = 4,
   parameter int RAM_WORDS     = 256,
   parameter int RAM_ADDR_BITS = 8,
   parameter int N_BITS        = 32,
   parameter int C_BITS        = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       go,
   input  logic [N_BITS-1:0]          base,
   output logic                       busy,
   output logic                       done,
   output logic [NCORES-1:0]          core_go,
   output logic [NCORES*N_BITS-1:0]   core_n,
   input  logic [NCORES-1:0]          core_done,
   input  logic [NCORES*C_BITS-1:0]   core_count,
   output logic                       we,
   output logic [RAM_ADDR_BITS-1:0]   waddr,
   output logic [C_BITS-1:0]          wdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic [1:0] C_FREE = 2'd0;
   localparam logic [1:0] C_BUSY = 2'd1;
   localparam logic [1:0] C_PEND = 2'd2;

   localparam int SW = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam int IW = RAM_ADDR_BITS + 1;

   logic [1:0]               state;
   logic [N_BITS-1:0]        base_r;
   logic [IW-1:0]            idx;
   logic [1:0]               cst [NCORES];
   logic [RAM_ADDR_BITS-1:0] tag [NCORES];
   logic [C_BITS-1:0]        cnt [NCORES];
   logic [N_BITS-1:0]        n_r [NCORES];

   logic          free_any;
   logic          pend_any;
   logic          all_free;
   logic [SW-1:0] free_sel;
   logic [SW-1:0] pend_sel;
   logic          issue_left;
   logic          dispatch;

   // Descending scan so the lowest-numbered matching core wins.
   always_comb begin
      free_any = 1'b0;
      pend_any = 1'b0;
      all_free = 1'b1;
      free_sel = '0;
      pend_sel = '0;
      for (int unsigned i = NCORES; i > 0; i--) begin
         if (cst[i-1] == C_FREE) begin
            free_any = 1'b1;
            free_sel = SW'(i - 1);
         end else begin
            all_free = 1'b0;
         end
         if (cst[i-1] == C_PEND) begin
            pend_any = 1'b1;
            pend_sel = SW'(i - 1);
         end
      end
   end

   assign issue_left = (idx < IW'(RAM_WORDS));
   assign dispatch   = (state == S_RUN) && issue_left && free_any;
   assign busy       = (state == S_RUN);
   assign done       = (state == S_FIN);

   for (genvar g = 0; g < NCORES; g++) begin : g_core_n
      assign core_n[g*N_BITS +: N_BITS] = n_r[g];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         base_r  <= '0;
         idx     <= '0;
         core_go <= '0;
         we      <= 1'b0;
         waddr   <= '0;
         wdata   <= '0;
         for (int unsigned k = 0; k < NCORES; k++) begin
            cst[k] <= C_FREE;
            tag[k] <= '0;
            cnt[k] <= '0;
            n_r[k] <= '0;
         end
      end else begin
         core_go <= '0;
         we      <= 1'b0;

         case (state)
            S_IDLE: if (go) begin
               base_r <= base;
               idx    <= '0;
               state  <= S_RUN;
            end
            // The registered write of the last result must have left before done.
            S_RUN:   if (!issue_left && all_free && !we) state <= S_FIN;
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         for (int unsigned k = 0; k < NCORES; k++) begin
            if (cst[k] == C_BUSY && core_done[k]) begin
               cnt[k] <= core_count[k*C_BITS +: C_BITS];
               cst[k] <= C_PEND;
            end
         end

         if (pend_any) begin
            we            <= 1'b1;
            waddr         <= tag[pend_sel];
            wdata         <= cnt[pend_sel];
            cst[pend_sel] <= C_FREE;
         end

         if (dispatch) begin
            core_go[free_sel] <= 1'b1;
            n_r[free_sel]     <= base_r + N_BITS'(idx);
            tag[free_sel]     <= idx[RAM_ADDR_BITS-1:0];
            cst[free_sel]     <= C_BUSY;
            idx               <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_collatz_dispatch.sv
// Bench for collatz_dispatch: behavioural cores with selectable latency and a
// scoreboard of expected start values and RAM contents per sweep.
module tb_collatz_dispatch;

   localparam int NC = 4;
   localparam int RW = 256;
   localparam int AB = 8;
   localparam int NB = 32;
   localparam int CB = 16;

   logic             clk;
   logic             reset;
   logic             go;
   logic [NB-1:0]    base;
   logic             busy;
   logic             done;
   logic [NC-1:0]    core_go;
   logic [NC*NB-1:0] core_n;
   logic [NC-1:0]    core_done;
   logic [NC*CB-1:0] core_count;
   logic             we;
   logic [AB-1:0]    waddr;
   logic [CB-1:0]    wdata;

   collatz_dispatch #(
      .NCORES(NC), .RAM_WORDS(RW), .RAM_ADDR_BITS(AB), .N_BITS(NB), .C_BITS(CB)
   ) dut (
      .clk(clk), .reset(reset), .go(go), .base(base), .busy(busy), .done(done),
      .core_go(core_go), .core_n(core_n), .core_done(core_done),
      .core_count(core_count), .we(we), .waddr(waddr), .wdata(wdata)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [NB-1:0] exp_n [$];
   logic [CB-1:0] exp_mem [RW];
   logic [CB-1:0] ram     [RW];
   logic          written [RW];
   int            wtime   [RW];
   int            nwr;
   bit            sweep_active = 0;
   int            lat_mode = 0;
   int            acc_cyc;
   int            disp_cnt    [NC];
   int            first_disp  [NC];
   int            second_disp [NC];
   int            first_done  [NC];

   bit            active [NC];
   int            timer  [NC];
   logic [CB-1:0] res    [NC];

   initial begin
      clk = 0;
      forever #10 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic int unsigned collatz(input logic [31:0] n0);
      logic [63:0]  n;
      int unsigned  s;
      n = {32'd0, n0};
      s = 0;
      while (n != 64'd1 && s < 1000) begin
         n = n[0] ? (n * 3 + 1) : (n >> 1);
         s++;
      end
      return s;
   endfunction

   function automatic int lat_of(input int k, input logic [CB-1:0] r);
      if (lat_mode == 1) return (r == 0) ? 1 : int'(r);
      if (lat_mode == 2) return (k == 1) ? 4 : 3;
      return 3;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Behavioural cores: done pulses lat_of() cycles after core_go is seen.
   initial begin
      core_done  = '0;
      core_count = '0;
      for (int k = 0; k < NC; k++) begin active[k] = 0; timer[k] = 0; res[k] = '0; end
      forever begin
         @(negedge clk);
         for (int k = 0; k < NC; k++) begin
            core_done[k] = 1'b0;
            if (reset) begin
               active[k] = 0;
            end else begin
               if (active[k]) begin
                  timer[k]--;
                  if (timer[k] == 0) begin
                     core_done[k] = 1'b1;
                     core_count[k*CB +: CB] = res[k];
                     active[k] = 0;
                     if (first_done[k] < 0) first_done[k] = cyc;
                  end
               end
               if (core_go[k]) begin
                  res[k]    = CB'(collatz(core_n[k*NB +: NB]));
                  timer[k]  = lat_of(k, res[k]);
                  active[k] = 1;
               end
            end
         end
      end
   end

   // Output monitor: dispatch order/values and RAM writes against the scoreboard.
   initial forever begin
      logic [NB-1:0] en;
      @(posedge clk);
      #1;
      if (!reset) begin
         if (core_go != '0) check("go_onehot", $onehot(core_go), 1);
         for (int k = 0; k < NC; k++) begin
            if (core_go[k]) begin
               check("go_in_sweep", sweep_active, 1);
               check("go_queue_nonempty", exp_n.size() > 0, 1);
               if (exp_n.size() > 0) begin
                  en = exp_n.pop_front();
                  check("core_n", core_n[k*NB +: NB], en);
               end
               disp_cnt[k]++;
               if (disp_cnt[k] == 1) first_disp[k] = cyc;
               if (disp_cnt[k] == 2) second_disp[k] = cyc;
            end
         end
         if (we) begin
            check("we_in_sweep", sweep_active, 1);
            check("waddr_range", waddr < AB'(RW - 1) || waddr == AB'(RW - 1), 1);
            check("waddr_once", written[waddr], 0);
            check("wdata", wdata, exp_mem[waddr]);
            written[waddr] = 1;
            ram[waddr]     = wdata;
            wtime[waddr]   = cyc;
            nwr++;
         end
         if (done) begin
            check("done_in_sweep", sweep_active, 1);
            check("done_nwr", nwr, RW);
            check("done_queue_empty", exp_n.size(), 0);
            check("busy_at_done", busy, 0);
            sweep_active = 0;
         end
      end
   end

   task automatic start_sweep(input logic [NB-1:0] b, input int mode);
      for (int i = 0; i < RW; i++) begin
         exp_mem[i] = CB'(collatz(b + 32'(i)));
         written[i] = 0;
         exp_n.push_back(b + 32'(i));
      end
      nwr = 0;
      for (int k = 0; k < NC; k++) begin
         disp_cnt[k] = 0; first_disp[k] = -1; second_disp[k] = -1; first_done[k] = -1;
      end
      lat_mode     = mode;
      sweep_active = 1;
      go   = 1'b1;
      base = b;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      check("busy_after_accept", busy, 1);
      check("no_go_at_accept", core_go, 0);
      @(negedge clk);
      go   = 1'b0;
      base = ~b;
   endtask

   task automatic wait_done();
      bit got;
      got = 0;
      for (int i = 0; i < 30000 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1;
      end
      check("done_timeout", got, 1);
   endtask

   task automatic sweep_checks();
      for (int k = 0; k < NC; k++) check("first_dispatch_cycle", first_disp[k], acc_cyc + 1 + k);
      check("done_to_we_latency", wtime[0], first_done[0] + 2);
   endtask

   initial begin
      reset = 1'b1;
      go    = 1'b0;
      base  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_we", we, 0);
      check("rst_waddr", waddr, 0);
      check("rst_wdata", wdata, 0);
      check("rst_core_go", core_go, 0);
      check("rst_core_n", core_n, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Fixed 3-cycle cores, base 1.
      start_sweep(32'd1, 0);
      wait_done();
      sweep_checks();
      check("ram0_count1", ram[0], 0);
      check("ram2_count3", ram[2], 7);
      check("ram26_count27", ram[26], 111);
      @(negedge clk);

      // Cores 1 and 2 finish together.
      start_sweep(32'd1, 2);
      wait_done();
      sweep_checks();
      check("tie_core1_first", wtime[2], wtime[1] + 1);
      check("tie_core1_redispatch_first", second_disp[1] < second_disp[2], 1);
      @(negedge clk);

      // Latency equal to the count: out-of-order completion.
      start_sweep(32'd7, 1);
      wait_done();
      sweep_checks();
      @(negedge clk);

      // go during RUN and in FIN is ignored; go right after done is accepted.
      start_sweep(32'd1, 0);
      repeat (20) @(negedge clk);
      go   = 1'b1;
      base = 32'd999;
      @(negedge clk);
      go   = 1'b0;
      wait_done();
      sweep_checks();
      go   = 1'b1;
      base = 32'd555;
      @(negedge clk);
      check("done_single_pulse", done, 0);
      start_sweep(32'd300, 0);
      wait_done();
      sweep_checks();
      @(negedge clk);

      // Abort mid-sweep.
      start_sweep(32'd1, 0);
      repeat (48) @(negedge clk);
      @(posedge clk);
      #2;
      reset        = 1'b1;
      sweep_active = 0;
      exp_n.delete();
      @(posedge clk);
      #1;
      check("abort_we", we, 0);
      check("abort_busy", busy, 0);
      check("abort_core_go", core_go, 0);
      check("abort_core_n", core_n, 0);
      check("abort_waddr", waddr, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_idle_we", we, 0);
      start_sweep(32'd100, 0);
      wait_done();
      sweep_checks();
      @(negedge clk);

      // Start value wraps past 2^32.
      start_sweep(32'hFFFF_FFF0, 0);
      wait_done();
      sweep_checks();
      check("wrap_ram16_n0", ram[16], CB'(collatz(32'd0)));
      check("wrap_ram15", ram[15], CB'(collatz(32'hFFFF_FFFF)));

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
